des_sbox_seq: RTL

- Time-multiplexed sequencer for the DES f-function substitution stage.
- Shares one external 8-way S-box bank (S1..S8 behind a select mux, combinational lookup) across the eight 6-bit chunks of a 48-bit expanded/key-mixed word.
- Assembles the eight 4-bit results into the 32-bit word that feeds the P permutation.
- Sits between the key-mix XOR and the P permutation inside the round datapath; the round controller starts it with a start/done handshake.

---
 rtl/des_sbox_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/des_sbox_seq.sv
// Time-multiplexed DES S-box sequencer: walks eight 6-bit chunks through one shared bank.
// Optional abort input enabled by defining DES_SBOX_SEQ_ABORT_EN.
module des_sbox_seq #(
  parameter int NUM_SBOX = 8,
  parameter int IN_W     = 6*NUM_SBOX,
  parameter int OUT_W    = 4*NUM_SBOX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  din,
`ifdef DES_SBOX_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       sel,
  output logic [5:0]       sbox_in,
  input  logic [3:0]       sbox_out,
  output logic [OUT_W-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [IN_W-1:0]  r_shreg;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_dout;
  logic [2:0]       r_sel;
  logic [5:0]       r_sbox_in;

  logic [OUT_W-1:0] w_acc_next;
  logic             w_last;
  logic             w_abort;

  assign w_acc_next = {r_acc[OUT_W-5:0], sbox_out};
  assign w_last     = (r_cnt == 3'd7);

`ifdef DES_SBOX_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // sel/sbox_in are registered copies of cnt and shreg[top] so the bank result never loops back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_shreg   <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
      r_sel     <= 3'd0;
      r_sbox_in <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shreg   <= din;
            r_cnt     <= 3'd0;
            r_sel     <= 3'd0;
            r_sbox_in <= din[IN_W-1 -: 6];
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_cnt   <= 3'd0;
            r_shreg <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_shreg <= r_shreg << 6;
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) begin
              r_dout  <= w_acc_next;
              r_state <= ST_DONE;
            end else begin
              r_sel     <= r_cnt + 3'd1;
              r_sbox_in <= r_shreg[IN_W-7 -: 6];
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign sbox_in   = r_sbox_in;
  assign dout      = r_dout;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule
